sbox_subbytes_seq: RTL and testbench

- Byte-serial SubBytes/InvSubBytes sequencer built around one shared `sbox` instance.
- Accepts a full cipher state over a valid/ready handshake, then streams its bytes through the S-box one per clock. It reassembles the substituted state and returns it over a second valid/ready handshake.
- Sits between the round controller and the S-box datapath, so a single S-box serves an entire round.

---
 rtl/sbox_subbytes_seq_pkg.sv | 13 +
 rtl/sbox.sv | 52 +++++
 rtl/sbox_subbytes_seq.sv | 120 ++++++++++++
 tb/tb_sbox_subbytes_seq.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/sbox_subbytes_seq_pkg.sv
// Shared types for the byte-serial SubBytes sequencer and its round controller.
package sbox_subbytes_seq_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam logic MODE_ENC = 1'b0;
   localparam logic MODE_DEC = 1'b1;

endpackage

// File: rtl/sbox.sv
// Combinational AES S-box: forward (ctrl=MODE_ENC) or inverse (ctrl=MODE_DEC),
// built from the GF(2^8) multiplicative inverse and the affine transform.
module sbox
   import sbox_subbytes_seq_pkg::*;
(
   input  logic [7:0] a,
   input  logic       ctrl,
   output logic [7:0] y
);

   function automatic logic [7:0] rotl(input logic [7:0] x, input int n);
      return 8'((x << n) | (x >> (8 - n)));
   endfunction

   function automatic logic [7:0] gf_mul(input logic [7:0] x, input logic [7:0] z);
      logic [7:0] p;
      logic [7:0] s;
      p = '0;
      s = x;
      for (int i = 0; i < 8; i++) begin
         if (z[i]) p = p ^ s;
         s = {s[6:0], 1'b0} ^ (s[7] ? 8'h1b : 8'h00);
      end
      return p;
   endfunction

   // x^254 is the field inverse and conveniently maps 0 to 0.
   function automatic logic [7:0] gf_inv(input logic [7:0] x);
      logic [7:0] r;
      logic [7:0] sq;
      r  = 8'h01;
      sq = x;
      for (int i = 0; i < 7; i++) begin
         sq = gf_mul(sq, sq);
         r  = gf_mul(r, sq);
      end
      return r;
   endfunction

   logic [7:0] fwd_inv;
   logic [7:0] fwd_y;
   logic [7:0] inv_pre;
   logic [7:0] inv_y;

   assign fwd_inv = gf_inv(a);
   assign fwd_y   = fwd_inv ^ rotl(fwd_inv, 1) ^ rotl(fwd_inv, 2) ^ rotl(fwd_inv, 3)
                    ^ rotl(fwd_inv, 4) ^ 8'h63;
   assign inv_pre = rotl(a, 1) ^ rotl(a, 3) ^ rotl(a, 6) ^ 8'h05;
   assign inv_y   = gf_inv(inv_pre);
   assign y       = (ctrl == MODE_DEC) ? inv_y : fwd_y;

endmodule

// File: rtl/sbox_subbytes_seq.sv
// Byte-serial SubBytes/InvSubBytes sequencer: accepts a state, streams each byte
// through one shared sbox, and returns the reassembled state.
module sbox_subbytes_seq
   import sbox_subbytes_seq_pkg::*;
#(
   parameter int NBYTES = 16,
   parameter int PIPE   = 1
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [8*NBYTES-1:0]   in_state,
   input  logic                  in_mode,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [8*NBYTES-1:0]   out_state,
   output logic                  out_mode,
   output logic                  busy
);

   localparam int             CW   = $clog2(NBYTES + 1);
   localparam logic [CW-1:0]  LAST = CW'(NBYTES - 1 + PIPE);

   state_t                state_q, state_d;
   logic [CW-1:0]         cnt_q;
   logic [CW-1:0]         wr_idx;
   logic                  wr_en;
   logic                  mode_q;
   logic [8*NBYTES-1:0]   work_q;
   logic [8*NBYTES-1:0]   result_q, result_d;
   logic [7:0]            cur_byte, sbox_a, sbox_y;
   logic                  accept;

   assign accept    = in_valid && in_ready;
   assign out_state = result_q;
   assign out_mode  = mode_q;

   // NOTE: state registers use non-blocking assignment so every flop samples
   // pre-edge values regardless of process ordering.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   // NOTE: every output of this block gets a default first so no path infers a latch.
   always_comb begin
      state_d   = state_q;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      busy      = 1'b1;
      case (state_q)
         IDLE: begin
            in_ready = 1'b1;
            busy     = 1'b0;
            if (in_valid) state_d = RUN;
         end
         RUN:  if (cnt_q == LAST) state_d = DONE;
         DONE: begin
            out_valid = 1'b1;
            if (out_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      cur_byte = '0;
      for (int i = 0; i < NBYTES; i++)
         if (cnt_q == CW'(i)) cur_byte = work_q[8*i +: 8];
   end

   always_comb begin
      result_d = result_q;
      for (int i = 0; i < NBYTES; i++)
         if (wr_en && (wr_idx == CW'(i))) result_d[8*i +: 8] = sbox_y;
   end

   if (PIPE != 0) begin : g_pipe
      logic [7:0] a_q;
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n)              a_q <= '0;
         else if (state_q == RUN) a_q <= cur_byte;
      end
      assign sbox_a = a_q;
      assign wr_en  = (state_q == RUN) && (cnt_q != '0);
      assign wr_idx = cnt_q - CW'(1);
   end else begin : g_comb
      assign sbox_a = cur_byte;
      assign wr_en  = (state_q == RUN);
      assign wr_idx = cnt_q;
   end

   // NOTE: the block-wide data registers are reset too, so a reset leaves
   // out_state and out_mode at zero rather than at a stale block.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q    <= '0;
         mode_q   <= MODE_ENC;
         work_q   <= '0;
         result_q <= '0;
      end else begin
         if (accept) begin
            work_q <= in_state;
            mode_q <= in_mode;
            cnt_q  <= '0;
         end else if ((state_q == RUN) && (cnt_q != LAST)) begin
            cnt_q  <= cnt_q + CW'(1);
         end
         result_q <= result_d;
      end
   end

   sbox u_sbox (
      .a    (sbox_a),
      .ctrl (mode_q),
      .y    (sbox_y)
   );

endmodule

// File: tb/tb_sbox_subbytes_seq.sv
// Directed bench for sbox_subbytes_seq at NBYTES=16, PIPE=1.
module tb_sbox_subbytes_seq;

   localparam logic [127:0] ZERO  = '0;
   localparam logic [127:0] ALL63 = {16{8'h63}};
   localparam logic [127:0] ALLFB = {16{8'hFB}};
   localparam logic [127:0] KIN   = {{13{8'h00}}, 8'hFF, 8'h01, 8'h53};
   localparam logic [127:0] KOUT  = {{13{8'h63}}, 8'h16, 8'h7C, 8'hED};

   logic         clk = 1'b0;
   logic         rst_n;
   logic         in_valid;
   logic         in_ready;
   logic [127:0] in_state;
   logic         in_mode;
   logic         out_valid;
   logic         out_ready;
   logic [127:0] out_state;
   logic         out_mode;
   logic         busy;

   int checks = 0;
   int errors = 0;

   logic [127:0] b_in  [3];
   logic [127:0] b_exp [3];
   logic         b_mode[3];

   always #5 clk = ~clk;

   sbox_subbytes_seq #(.NBYTES(16), .PIPE(1)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_state  (in_state),
      .in_mode   (in_mode),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_state (out_state),
      .out_mode  (out_mode),
      .busy      (busy)
   );

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] expd);
      checks++;
      assert (obs === expd) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, expd);
      end
   endtask

   // Called at a negedge while IDLE; returns at the negedge after the accept edge.
   task automatic send_block(input logic [127:0] st, input logic md);
      in_state = st;
      in_mode  = md;
      in_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
   endtask

   task automatic wait_out(output int cyc);
      cyc = 0;
      while (!out_valid && cyc < 100) begin
         @(posedge clk);
         cyc++;
         @(negedge clk);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog");
   end

   initial begin
      int lat;
      int seen;
      int idx_in, idx_out, cyc, last_t;
      logic pend;

      rst_n     = 1'b0;
      in_valid  = 1'b0;
      in_state  = '0;
      in_mode   = 1'b0;
      out_ready = 1'b0;
      repeat (2) @(negedge clk);
      check("rst_out_valid", out_valid, 1'b0);
      check("rst_busy",      busy,      1'b0);
      check("rst_out_state", out_state, ZERO);
      check("rst_out_mode",  out_mode,  1'b0);
      rst_n = 1'b1;
      @(negedge clk);
      check("rst_in_ready",  in_ready,  1'b1);

      // All-zero forward block.
      out_ready = 1'b1;
      send_block(ZERO, 1'b0);
      check("run_busy", busy, 1'b1);
      check("run_in_ready", in_ready, 1'b0);
      wait_out(lat);
      check("zero_latency", lat, 17);
      check("zero_state", out_state, ALL63);
      check("zero_mode", out_mode, 1'b0);
      @(posedge clk);
      @(negedge clk);
      check("zero_drop_valid", out_valid, 1'b0);
      check("zero_idle_ready", in_ready, 1'b1);

      // Known bytes forward.
      send_block(KIN, 1'b0);
      wait_out(lat);
      check("fwd_latency", lat, 17);
      check("fwd_state", out_state, KOUT);
      check("fwd_mode", out_mode, 1'b0);
      @(posedge clk);
      @(negedge clk);

      // Inverse recovers the original state.
      send_block(KOUT, 1'b1);
      wait_out(lat);
      check("inv_state", out_state, KIN);
      check("inv_mode", out_mode, 1'b1);
      @(posedge clk);
      @(negedge clk);

      // Backpressure with an ignored second request.
      out_ready = 1'b0;
      send_block(KIN, 1'b0);
      wait_out(lat);
      check("bp_latency", lat, 17);
      for (int i = 0; i < 10; i++) begin
         check("bp_valid", out_valid, 1'b1);
         check("bp_state", out_state, KOUT);
         check("bp_in_ready", in_ready, 1'b0);
         if (i == 3) begin
            in_state = ALL63;
            in_mode  = 1'b1;
            in_valid = 1'b1;
         end
         @(posedge clk);
         @(negedge clk);
      end
      in_valid  = 1'b0;
      check("bp_mode", out_mode, 1'b0);
      out_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      check("bp_after_valid", out_valid, 1'b0);
      check("bp_after_ready", in_ready, 1'b1);
      check("bp_after_busy", busy, 1'b0);

      // Reset in RUN cycle 7.
      send_block(KIN, 1'b0);
      repeat (7) @(negedge clk);
      check("mid_busy_before", busy, 1'b1);
      rst_n = 1'b0;
      #1;
      check("mid_rst_busy", busy, 1'b0);
      check("mid_rst_valid", out_valid, 1'b0);
      @(negedge clk);
      rst_n = 1'b1;
      seen = 0;
      for (int i = 0; i < 25; i++) begin
         @(negedge clk);
         if (out_valid) seen++;
      end
      check("mid_no_output", seen, 0);
      check("mid_state_cleared", out_state, ZERO);
      send_block(ALL63, 1'b0);
      wait_out(lat);
      check("post_rst_latency", lat, 17);
      check("post_rst_state", out_state, ALLFB);
      @(posedge clk);
      @(negedge clk);

      // Back-to-back blocks with alternating modes.
      b_in[0] = ZERO;  b_mode[0] = 1'b0; b_exp[0] = ALL63;
      b_in[1] = KOUT;  b_mode[1] = 1'b1; b_exp[1] = KIN;
      b_in[2] = KIN;   b_mode[2] = 1'b0; b_exp[2] = KOUT;
      idx_in   = 0;
      idx_out  = 0;
      cyc      = 0;
      last_t   = 0;
      pend     = 1'b0;
      in_state = b_in[0];
      in_mode  = b_mode[0];
      in_valid = 1'b1;
      while (idx_out < 3 && cyc < 200) begin
         if (pend) begin
            idx_in++;
            if (idx_in < 3) begin
               in_state = b_in[idx_in];
               in_mode  = b_mode[idx_in];
            end else begin
               in_valid = 1'b0;
            end
         end
         pend = in_valid && in_ready;
         if (out_valid) begin
            check("b2b_state", out_state, b_exp[idx_out]);
            check("b2b_mode", out_mode, b_mode[idx_out]);
            if (idx_out > 0) check("b2b_spacing", cyc - last_t, 19);
            last_t = cyc;
            idx_out++;
         end
         @(posedge clk);
         @(negedge clk);
         cyc++;
      end
      in_valid = 1'b0;
      check("b2b_count", idx_out, 3);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
